spi_page_write_sched: RTL

- Downstream consumer of the SPI read path's byte FIFO.
- Drains bytes read from ROM A and splits the stream into page-program bursts that never cross a flash page boundary.
- Hands each burst (address, length, data bytes) to the ROM B write serializer over a request/ack plus valid/ready interface.
- Reports progress (busy, done, bytes_written) to the top-level status logic.

---
 rtl/spi_page_write_sched_pkg.sv | 25 ++
 rtl/spi_page_write_sched_if.sv | 28 ++
 rtl/spi_page_write_sched_chunk_calc.sv | 32 +++
 rtl/spi_page_write_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_page_write_sched_pkg.sv
// Shared definitions for the SPI page-write scheduler.
//   - FSM state encodings
//   - default flash page size (FLASH_PAGE_SIZE)
//   - page-offset mask helper
package spi_page_write_sched_pkg;

  localparam int FLASH_PAGE_SIZE = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALC      = 3'd1,
    ST_REQ       = 3'd2,
    ST_XFER      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Mask selecting the in-page offset bits of a flash address.
  function automatic logic [31:0] page_off_mask(input int page_size);
    return 32'(page_size - 1);
  endfunction

  localparam logic [31:0] FLASH_PAGE_MASK = page_off_mask(FLASH_PAGE_SIZE);

endpackage

// File: rtl/spi_page_write_sched_if.sv
// Scheduler <-> ROM B write serializer bus.
//   pp_req/pp_addr/pp_len/pp_ack : page-program request handshake
//   byte_valid/byte_data/byte_req: byte stream, transfers on valid && req
//   pp_done                      : writer finished programming the page
// master = scheduler, slave = writer.
interface spi_page_write_sched_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 9
);
  logic              pp_req;
  logic [ADDR_W-1:0] pp_addr;
  logic [LEN_W-1:0]  pp_len;
  logic              pp_ack;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_req;
  logic              pp_done;

  modport master (
    output pp_req, pp_addr, pp_len, byte_valid, byte_data,
    input  pp_ack, byte_req, pp_done
  );

  modport slave (
    input  pp_req, pp_addr, pp_len, byte_valid, byte_data,
    output pp_ack, byte_req, pp_done
  );
endinterface

// File: rtl/spi_page_write_sched_chunk_calc.sv
// spi_chunk_calc: combinational burst-size calculator.
//   addr      : current destination address
//   remaining : bytes still to copy
//   chunk     : min(PAGE_SIZE - (addr mod PAGE_SIZE), remaining)
module spi_chunk_calc
  import spi_page_write_sched_pkg::*;
#(
  parameter int PAGE_SIZE = FLASH_PAGE_SIZE,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int LEN_W     = $clog2(PAGE_SIZE) + 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  remaining,
  output logic [LEN_W-1:0]  chunk
);
  localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(page_off_mask(PAGE_SIZE));

  logic [ADDR_W-1:0] off_full;
  logic [LEN_W-1:0]  room;
  logic [CMP_W-1:0]  room_x, rem_x;

  always_comb begin
    off_full = addr & OFF_MASK;
    // Room left in the page is 1..PAGE_SIZE, so it always fits LEN_W.
    room   = LEN_W'(PAGE_SIZE) - LEN_W'(off_full);
    room_x = CMP_W'(room);
    rem_x  = CMP_W'(remaining);
    chunk  = (rem_x < room_x) ? LEN_W'(remaining) : room;
  end
endmodule

// File: rtl/spi_page_write_sched.sv
// spi_page_write_sched: drains the SPI read FIFO and issues page-program
// bursts to the ROM B writer without crossing a flash page boundary.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : job start pulse (ignored while busy or on done)
//   dst_start_addr      : first destination address
//   total_len           : bytes to copy
//   fifo_empty/fifo_data/fifo_rd_en : read FIFO (data one cycle after pop)
//   wr                  : writer bus (spi_page_write_sched_if.master)
//   busy, done          : job status; done is a one-cycle pulse
//   bytes_written       : bytes handed to the writer this/last job
//   checksum            : 8-bit byte sum, only with SPI_COPY_CHECKSUM_EN
// Optional feature macro: SPI_COPY_CHECKSUM_EN (undefined -> checksum = 0).
module spi_page_write_sched
  import spi_page_write_sched_pkg::*;
#(
  parameter int PAGE_SIZE = FLASH_PAGE_SIZE,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  localparam int LEN_W    = $clog2(PAGE_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     dst_start_addr,
  input  logic [CNT_W-1:0]      total_len,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_data,
  output logic                  fifo_rd_en,
  spi_page_write_sched_if.master wr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bytes_written,
  output logic [7:0]            checksum
);

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [LEN_W-1:0]  page_cnt, fetch_cnt, chunk;
  logic [7:0]        hold_data;
  logic              hold_valid;
  logic              pop_pend;
  logic              pp_req_q;
  logic [ADDR_W-1:0] pp_addr_q;
  logic [LEN_W-1:0]  pp_len_q;
  logic              done_q;
  logic [CNT_W-1:0]  bw_q;
  logic              hs, pop, start_acc;

  spi_chunk_calc #(
    .PAGE_SIZE (PAGE_SIZE),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .LEN_W     (LEN_W)
  ) u_chunk (
    .addr      (addr),
    .remaining (remaining),
    .chunk     (chunk)
  );

  // The hold register only carries data during XFER, so hs implies XFER.
  assign hs        = hold_valid & wr.byte_req;
  // done_q high means the FSM just left DONE; a start in that cycle is dropped.
  assign start_acc = start & (state == ST_IDLE) & ~done_q;
  // One pop in flight at a time; the popped byte needs an empty (or emptying)
  // hold register one cycle later.
  assign pop = ~rst & (state == ST_XFER) & (~hold_valid | hs) & ~pop_pend &
               ~fifo_empty & (fetch_cnt != '0);

  assign fifo_rd_en    = pop;
  assign wr.pp_req     = pp_req_q;
  assign wr.pp_addr    = pp_addr_q;
  assign wr.pp_len     = pp_len_q;
  assign wr.byte_valid = hold_valid;
  assign wr.byte_data  = hold_data;
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign bytes_written = bw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      page_cnt   <= '0;
      fetch_cnt  <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      pop_pend   <= 1'b0;
      pp_req_q   <= 1'b0;
      pp_addr_q  <= '0;
      pp_len_q   <= '0;
      done_q     <= 1'b0;
      bw_q       <= '0;
    end else begin
      done_q   <= 1'b0;
      pop_pend <= pop;
      if (pop) fetch_cnt <= fetch_cnt - 1'b1;

      if (pop_pend) begin
        hold_data  <= fifo_data;
        hold_valid <= 1'b1;
      end else if (hs) begin
        hold_valid <= 1'b0;
      end

      if (hs) begin
        page_cnt  <= page_cnt - 1'b1;
        remaining <= remaining - 1'b1;
        addr      <= addr + 1'b1;
        bw_q      <= bw_q + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            addr      <= dst_start_addr;
            remaining <= total_len;
            bw_q      <= '0;
            state     <= (total_len == '0) ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          page_cnt  <= chunk;
          fetch_cnt <= chunk;
          pp_req_q  <= 1'b1;
          pp_addr_q <= addr;
          pp_len_q  <= chunk;
          state     <= ST_REQ;
        end
        ST_REQ: begin
          if (wr.pp_ack) begin
            pp_req_q <= 1'b0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (hs && page_cnt == LEN_W'(1)) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (wr.pp_done) state <= (remaining != '0) ? ST_CALC : ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_COPY_CHECKSUM_EN
  logic [7:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst)            csum_q <= 8'h00;
    else if (start_acc) csum_q <= 8'h00;
    else if (hs)        csum_q <= csum_q + hold_data;
  end
  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule
